// File: rtl/dcc_pio_pkg.sv
// -----------------------------------------------------------------------------
// dcc_pio_pkg
// Shared definitions for the DCC data PIO irq sequencer:
//   - Avalon-MM register offsets of the PIO (data, irq mask, edge capture)
//   - sequencer FSM state encoding
//   - saturating increment helper for the 16-bit overflow counter
// -----------------------------------------------------------------------------
package dcc_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT_MASK = 3'd0,
        ST_IDLE      = 3'd1,
        ST_RD_EDGE   = 3'd2,
        ST_WAIT_EDGE = 3'd3,
        ST_RD_DATA   = 3'd4,
        ST_WAIT_DATA = 3'd5,
        ST_CLR_EDGE  = 3'd6,
        ST_PUSH      = 3'd7
    } seq_state_t;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dcc_sync_fifo.sv
// -----------------------------------------------------------------------------
// dcc_sync_fifo
// Single-clock first-word-fall-through FIFO. dout shows the head entry whenever
// empty=0 and reads as zero when empty.
// A push while full is accepted only if a pop happens in the same cycle.
// A pop while empty is ignored.
// Ports:
//   clk, reset_n : clock, async active-low reset (pointers/count only)
//   push, din    : write request and data
//   full         : no free entry
//   pop          : consume head entry
//   empty, dout  : FIFO empty flag, head entry
// -----------------------------------------------------------------------------
module dcc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_MAX);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/dcc_pio_irq_sequencer.sv
// -----------------------------------------------------------------------------
// dcc_pio_irq_sequencer
// Avalon-MM master owning the DCC data PIO. After reset it programs the PIO
// irq mask, then services every PIO irq by reading edge capture and data,
// clearing edge capture, and pushing a timestamped record {ts, edges, data}
// into a FWFT FIFO drained over a valid/ready stream.
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   enable              : 1 = service irqs; 0 = finish current sequence, park
//   pio_address/_chipselect/_write_n/_writedata : Avalon-MM master to the PIO
//   pio_readdata        : registered PIO read data (valid 1 cycle after addr)
//   pio_irq             : PIO interrupt (edge_capture & mask)
//   m_data/m_valid/m_ready : record stream out
//   overflow_count      : records dropped on full FIFO (saturating)
//   busy                : FSM not in IDLE
// -----------------------------------------------------------------------------
module dcc_pio_irq_sequencer
    import dcc_pio_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] IRQ_MASK   = 32'hFFFF_FFFF,
    parameter int                TS_W       = 32,
    parameter int                FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    output logic [1:0]               pio_address,
    output logic                     pio_chipselect,
    output logic                     pio_write_n,
    output logic [DATA_W-1:0]        pio_writedata,
    input  logic [DATA_W-1:0]        pio_readdata,
    input  logic                     pio_irq,
    output logic [TS_W+2*DATA_W-1:0] m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [15:0]              overflow_count,
    output logic                     busy
);

    localparam int REC_W = TS_W + 2 * DATA_W;

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic              arm_q;
    logic [TS_W-1:0]   ts_cnt_q;
    logic [TS_W-1:0]   ts_q;
    logic [DATA_W-1:0] edges_q;
    logic [DATA_W-1:0] data_q;
    logic [15:0]       ovf_q;
    logic [15:0]       ovf_d;
    logic              has_edges;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;

    // Bus outputs decode straight from the state, so an async reset releases
    // the bus in the same cycle. arm_q keeps the bus quiet while reset is held
    // and during the first cycle after release, when the state is already
    // INIT_MASK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_q <= 1'b0;
        end else begin
            arm_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
        end
    end

    assign has_edges = |(edges_q & IRQ_MASK);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT_MASK: if (arm_q) state_d = ST_IDLE;
            ST_IDLE:      if (enable && pio_irq) state_d = ST_RD_EDGE;
            ST_RD_EDGE:   state_d = ST_WAIT_EDGE;
            // Decide on the value being captured, not the stale edges_q.
            ST_WAIT_EDGE: state_d = ((pio_readdata & IRQ_MASK) == '0) ? ST_CLR_EDGE
                                                                       : ST_RD_DATA;
            ST_RD_DATA:   state_d = ST_WAIT_DATA;
            ST_WAIT_DATA: state_d = ST_CLR_EDGE;
            ST_CLR_EDGE:  state_d = has_edges ? ST_PUSH : ST_IDLE;
            ST_PUSH:      state_d = ST_IDLE;
            default:      state_d = ST_INIT_MASK;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT_MASK;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture registers only ever reach the outputs through gated paths
    // (FIFO dout, CLR_EDGE write), so they carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && enable && pio_irq) begin
            ts_q <= ts_cnt_q;
        end
        if (state_q == ST_WAIT_EDGE) begin
            edges_q <= pio_readdata;
        end
        if (state_q == ST_WAIT_DATA) begin
            data_q <= pio_readdata;
        end
    end

    always_comb begin
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_address    = 2'd0;
        pio_writedata  = '0;
        if (arm_q) begin
            case (state_q)
                ST_INIT_MASK: begin
                    pio_chipselect = 1'b1;
                    pio_write_n    = 1'b0;
                    pio_address    = PIO_ADDR_MASK;
                    pio_writedata  = IRQ_MASK;
                end
                ST_RD_EDGE: begin
                    pio_chipselect = 1'b1;
                    pio_address    = PIO_ADDR_EDGE;
                end
                ST_RD_DATA: begin
                    pio_chipselect = 1'b1;
                    pio_address    = PIO_ADDR_DATA;
                end
                ST_CLR_EDGE: begin
                    pio_chipselect = 1'b1;
                    pio_write_n    = 1'b0;
                    pio_address    = PIO_ADDR_EDGE;
                    pio_writedata  = edges_q;
                end
                default: ;
            endcase
        end
    end

    assign fifo_push = (state_q == ST_PUSH);
    // Full only drops when the consumer is not popping in the same cycle.
    assign drop      = fifo_push & fifo_full & ~(m_valid & m_ready);
    assign ovf_d     = drop ? sat_inc16(ovf_q) : ovf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    dcc_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     ({ts_q, edges_q, data_q}),
        .full    (fifo_full),
        .pop     (m_ready),
        .empty   (fifo_empty),
        .dout    (m_data)
    );

    assign m_valid        = ~fifo_empty;
    assign overflow_count = ovf_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dcc_pio_irq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dcc_pio_irq_sequencer
// Directed bench for dcc_pio_irq_sequencer with a behavioural PIO model
// (rising-edge capture, whole-register clear, registered readdata). The PIO
// model is not reset by reset_n, so edge capture survives a sequencer reset.
// -----------------------------------------------------------------------------
module tb_dcc_pio_irq_sequencer;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b1;
    logic        m_ready = 1'b0;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata = 32'h0;
    logic        pio_irq;
    logic [95:0] m_data;
    logic        m_valid;
    logic [15:0] overflow_count;
    logic        busy;

    // PIO model state
    logic [31:0] in_port  = 32'h0;
    logic [31:0] in_prev  = 32'h0;
    logic [31:0] edge_cap = 32'h0;
    logic [31:0] mask_reg = 32'h0;

    logic        mon_clr    = 1'b0;
    int          mask_writes = 0;
    logic [31:0] exp_ts      = 32'h0;
    logic [95:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dcc_pio_irq_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pio_irq        (pio_irq),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .overflow_count (overflow_count),
        .busy           (busy)
    );

    assign pio_irq = |(edge_cap & mask_reg);

    always @(posedge clk) begin
        in_prev <= in_port;
        case (pio_address)
            2'd0:    pio_readdata <= in_port;
            2'd2:    pio_readdata <= mask_reg;
            2'd3:    pio_readdata <= edge_cap;
            default: pio_readdata <= 32'h0;
        endcase
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
            edge_cap <= 32'h0;
        else
            edge_cap <= edge_cap | (in_port & ~in_prev);
        if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
            mask_reg <= pio_writedata;
    end

    always @(posedge clk) begin
        if (mon_clr)
            mask_writes <= 0;
        else if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
            mask_writes <= mask_writes + 1;
    end

    // Expected free-running timestamp: 0 in the first cycle after reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) exp_ts <= 32'h0;
        else          exp_ts <= exp_ts + 32'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Produce a rising edge pattern v on in_port and return the timestamp of
    // the first cycle in which pio_irq is seen high.
    task automatic fire_event(input logic [31:0] v, output logic [31:0] ts_seen);
        logic got;
        got     = 1'b0;
        ts_seen = 32'h0;
        in_port = 32'h0;
        tick();
        in_port = v;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (pio_irq) begin
                got     = 1'b1;
                ts_seen = exp_ts;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL irq_wait: pio_irq=0 after 10 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++;
        if ({pio_chipselect, pio_write_n, pio_address} !== 4'b0100) begin
            bad++;
            $display("FAIL reset_bus: cs/wn/addr=%b, required 0100",
                     {pio_chipselect, pio_write_n, pio_address});
        end
        total++;
        if (pio_writedata !== 32'h0) begin
            bad++;
            $display("FAIL reset_wdata: got %h, required 0", pio_writedata);
        end
        total++;
        if ({m_valid, busy} !== 2'b01 || m_data !== 96'h0 || overflow_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_stream: valid=%b busy=%b data=%h ovf=%h, required 0 1 0 0",
                     m_valid, busy, m_data, overflow_count);
        end
        reset_n = 1'b1;
        repeat (6) tick();
        total++;
        if (mask_writes !== 1 || mask_reg !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL init_mask: writes=%0d mask=%h, required 1 FFFFFFFF",
                     mask_writes, mask_reg);
        end
        total++;
        if ({busy, pio_chipselect, pio_write_n, pio_address} !== 5'b00100) begin
            bad++;
            $display("FAIL idle_bus: busy/cs/wn/addr=%b, required 00100",
                     {busy, pio_chipselect, pio_write_n, pio_address});
        end
    endtask

    task automatic test_single_record();
        logic [31:0] t;
        fire_event(32'h0000_0005, t);
        repeat (6) tick();
        total++;
        if (m_valid !== 1'b0 || pio_irq !== 1'b0 || edge_cap !== 32'h0) begin
            bad++;
            $display("FAIL single_t6: valid=%b irq=%b edge=%h, required 0 0 0",
                     m_valid, pio_irq, edge_cap);
        end
        tick();
        total++;
        if (m_valid !== 1'b1 || m_data !== {t, 32'h5, 32'h5} || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_t7: valid=%b busy=%b data=%h, required 1 0 %h",
                     m_valid, busy, m_data, {t, 32'h5, 32'h5});
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        total++;
        if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_pop: valid=%b, required 0", m_valid);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] t;
        logic [31:0] prev_ts;
        logic [95:0] r;
        m_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            fire_event(32'(k + 1), t);
            if (k < 8) exp_q.push_back({t, 32'(k + 1), 32'(k + 1)});
            repeat (8) tick();
        end
        total++;
        if (overflow_count !== 16'd2 || m_valid !== 1'b1) begin
            bad++;
            $display("FAIL ovf_count: ovf=%0d valid=%b, required 2 1", overflow_count, m_valid);
        end
        m_ready = 1'b1;
        prev_ts = 32'h0;
        for (int i = 0; i < 8; i++) begin
            r = exp_q.pop_front();
            total++;
            if (m_valid !== 1'b1 || m_data !== r) begin
                bad++;
                $display("FAIL ovf_drain%0d: valid=%b data=%h, required 1 %h", i, m_valid, m_data, r);
            end
            if (i > 0) begin
                total++;
                if (!(m_data[95:64] > prev_ts)) begin
                    bad++;
                    $display("FAIL ovf_ts_order%0d: ts=%h, required > %h", i, m_data[95:64], prev_ts);
                end
            end
            prev_ts = m_data[95:64];
            tick();
        end
        m_ready = 1'b0;
        total++;
        if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL ovf_empty: valid=%b, required 0", m_valid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] t;
        logic [95:0] r;
        m_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            fire_event(32'h100 + 32'(k), t);
            exp_q.push_back({t, 32'h100 + 32'(k), 32'h100 + 32'(k)});
            repeat (8) tick();
        end
        fire_event(32'h0000_01FF, t);
        repeat (6) tick();
        r = exp_q.pop_front();
        total++;
        if (busy !== 1'b1 || m_data !== r) begin
            bad++;
            $display("FAIL full_head: busy=%b data=%h, required 1 %h", busy, m_data, r);
        end
        exp_q.push_back({t, 32'h1FF, 32'h1FF});
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        total++;
        if (overflow_count !== 16'd2) begin
            bad++;
            $display("FAIL full_no_drop: ovf=%0d, required 2", overflow_count);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = exp_q.pop_front();
            total++;
            if (m_valid !== 1'b1 || m_data !== r) begin
                bad++;
                $display("FAIL full_drain%0d: valid=%b data=%h, required 1 %h", i, m_valid, m_data, r);
            end
            tick();
        end
        m_ready = 1'b0;
        total++;
        if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL full_empty: valid=%b, required 0", m_valid);
        end
    endtask

    task automatic test_enable();
        logic [31:0] t;
        logic [31:0] u;
        fire_event(32'h0000_00A0, t);
        repeat (3) tick();
        total++;
        if (pio_chipselect !== 1'b1 || pio_address !== 2'd0) begin
            bad++;
            $display("FAIL en_rd_data: cs=%b addr=%0d, required 1 0", pio_chipselect, pio_address);
        end
        enable = 1'b0;
        repeat (4) tick();
        total++;
        if (m_valid !== 1'b1 || m_data !== {t, 32'hA0, 32'hA0} || busy !== 1'b0) begin
            bad++;
            $display("FAIL en_complete: valid=%b busy=%b data=%h, required 1 0 %h",
                     m_valid, busy, m_data, {t, 32'hA0, 32'hA0});
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        fire_event(32'h0000_0C00, t);
        repeat (10) tick();
        total++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || pio_irq !== 1'b1) begin
            bad++;
            $display("FAIL en_parked: busy=%b valid=%b irq=%b, required 0 0 1", busy, m_valid, pio_irq);
        end
        enable = 1'b1;
        u = exp_ts;
        repeat (7) tick();
        total++;
        if (m_valid !== 1'b1 || m_data !== {u, 32'hC00, 32'hC00}) begin
            bad++;
            $display("FAIL en_resume: valid=%b data=%h, required 1 %h", m_valid, m_data, {u, 32'hC00, 32'hC00});
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid_sequence();
        logic [31:0] t;
        logic [31:0] u;
        fire_event(32'h0000_3000, t);
        repeat (8) tick();
        fire_event(32'h0005_0000, t);
        repeat (3) tick();
        total++;
        if (pio_chipselect !== 1'b1 || m_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: cs=%b valid=%b, required 1 1", pio_chipselect, m_valid);
        end
        tick();
        reset_n = 1'b0;
        #1;
        total++;
        if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || m_valid !== 1'b0 ||
            busy !== 1'b1 || overflow_count !== 16'h0) begin
            bad++;
            $display("FAIL rst_async: cs=%b wn=%b valid=%b busy=%b ovf=%0d, required 0 1 0 1 0",
                     pio_chipselect, pio_write_n, m_valid, busy, overflow_count);
        end
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        total++;
        if ({pio_chipselect, pio_write_n, pio_address} !== 4'b1010 || pio_writedata !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL rst_remask: cs/wn/addr=%b data=%h, required 1010 FFFFFFFF",
                     {pio_chipselect, pio_write_n, pio_address}, pio_writedata);
        end
        tick();
        u = exp_ts;
        total++;
        if (busy !== 1'b0 || pio_irq !== 1'b1) begin
            bad++;
            $display("FAIL rst_idle: busy=%b irq=%b, required 0 1", busy, pio_irq);
        end
        repeat (7) tick();
        total++;
        if (m_valid !== 1'b1 || m_data !== {u, 32'h0005_0000, 32'h0005_0000} || mask_writes !== 1) begin
            bad++;
            $display("FAIL rst_service: valid=%b data=%h writes=%0d, required 1 %h 1",
                     m_valid, m_data, mask_writes, {u, 32'h0005_0000, 32'h0005_0000});
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_record();
        test_overflow();
        test_full_push_pop();
        test_enable();
        test_reset_mid_sequence();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
